crc_frame_sched: RTL
====================

# crc_frame_sched

Round-robin scheduler that shares one 4-bit-per-cycle CRC-3 divider (generator 1001, x^3+1) between N_REQ nibble-stream requesters. The block grants one requester at a time for a whole frame and feeds its nibbles through the divider, one per cycle. It then presents the 3-bit remainder with owner ID and frame length on a valid/ready result port. It sits between the packet framers and the link layer that appends or checks the CRC.

## Interface
- N_REQ, 2, number of requesters (2..8)
- ID_W, 1, width of owner ID; must satisfy 2^ID_W >= N_REQ
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  N_REQ  per-requester nibble valid
- in_last  in  N_REQ  per-requester last-nibble-of-frame flag, qualified by in_valid
- in_data  in  4*N_REQ  nibble for requester i in bits [4i+3:4i], MSB first on the wire
- in_ready  out  N_REQ  per-requester accept; one-hot or zero
- grant  out  N_REQ  one-hot owner of the divider; zero when unowned
- out_valid  out  1  result available
- out_rem  out  3  CRC remainder of the frame
- out_id  out  ID_W  index of the requester that owned the frame
- out_len  out  8  nibbles in the frame, saturating at 255
- out_ready  in  1  result consumer accept

## Operation
- States: IDLE, BUSY, HOLD. Reset enters IDLE with grant=0, in_ready=0, out_valid=0, out_rem=0, out_id=0, out_len=0, rr pointer=0, remainder reg=0, count=0.
- IDLE: if any in_valid is set, pick the first set index scanning upward from the rr pointer, with modulo wrap. Register grant one-hot for that index. Clear the remainder and count, then go to BUSY. If no in_valid is set, stay in IDLE.
- BUSY: in_ready = grant. A beat occurs when in_valid&in_ready for the owner.
- Per beat, the remainder r updates bit-serially over the nibble, MSB first: fb=r[2]^b; r={r[1:0],1'b0}^{2'b00,fb}.
- The result equals M(x)*x^3 mod (x^3+1). No flush cycles are needed.
- Each beat increments count. The count saturates at 255.
- On a beat with in_last set: load out_rem with the updated r. Load out_len with the updated count and out_id with the owner index. Set out_valid, clear grant and in_ready, and go to HOLD.
- Non-owner inputs are ignored. Their in_valid may stay high indefinitely without effect.
- HOLD: out_* are stable while out_valid=1 and out_ready=0. On out_valid&out_ready: clear out_valid, set rr pointer=out_id+1 (wrapping to 0 at N_REQ), and go to IDLE.
- Owner deasserting in_valid mid-frame: BUSY waits indefinitely; there is no timeout.
- Asserting reset mid-frame or in HOLD discards the partial frame or pending result. All outputs return to their reset values asynchronously.

## Timing
- Request seen in IDLE at cycle t gives grant/in_ready at t+1. The first beat can occur at t+1.
- Throughput in BUSY: one nibble per cycle.
- The last beat at cycle u gives out_valid at u+1. The result can be accepted at u+1 if out_ready=1.
- After acceptance at cycle v, the state is IDLE at v+1 and the next grant comes at v+2. There is a 2-cycle gap between frames.
- in_ready and grant are registered. in_ready never depends combinationally on in_valid.
- out_valid is registered. out_ready has no combinational path to any output.

## Configuration
- Macro CRC_FRAME_CHECK_EN.
- Defined:
  - Adds input in_exp (3*N_REQ), sampled on the owner's last beat.
  - Adds output out_err (1), registered alongside out_rem.
  - out_err=1 when the computed remainder is not equal to in_exp for the owner; out_err resets to 0.
- Undefined: in_exp and out_err ports do not exist. The rest of the behaviour is identical.

## Test plan
- Single frame: requester 0 sends one nibble 4'hB with last=1 -> out_rem=3'b010, out_len=1, out_id=0, out_valid one cycle after the beat.
- Single nibble 4'hF, then a two-nibble frame 4'h1,4'h0 -> out_rem=3'b110 and 3'b010 respectively, out_len=1 then 2.
- Both requesters hold in_valid continuously -> grants alternate 0,1,0,1. Each frame accepts only the owner's nibbles, and the non-owner's in_ready stays 0.
- out_ready held low 5 cycles after a result -> out_rem/out_id/out_len stable; the next grant comes 2 cycles after out_ready rises.
- 300-nibble frame of 4'h0 -> out_len=255 and out_rem=3'b000. Reset asserted mid-frame -> outputs zero immediately, and the next frame's remainder is unaffected by the partial frame.
- CRC_FRAME_CHECK_EN: nibble 4'hB with in_exp=3'b010 -> out_err=0; with in_exp=3'b011 -> out_err=1.

Source files
------------

// File: rtl/crc_frame_sched.sv
// crc_frame_sched: round-robin scheduler sharing one nibble-wide CRC-3
// divider (generator x^3+1) between N_REQ requesters, one whole frame per
// grant, with the remainder, owner and length on a valid/ready result port.
// Optional feature macro: CRC_FRAME_CHECK_EN adds in_exp / out_err, which flag
// a mismatch between the computed remainder and the owner's expected value.
module crc_frame_sched #(
   parameter int N_REQ = 2,
   parameter int ID_W  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
`ifdef CRC_FRAME_CHECK_EN
   input  logic [3*N_REQ-1:0]   in_exp,
   output logic                 out_err,
`endif
   input  logic [N_REQ-1:0]     in_valid,
   input  logic [N_REQ-1:0]     in_last,
   input  logic [4*N_REQ-1:0]   in_data,
   output logic [N_REQ-1:0]     in_ready,
   output logic [N_REQ-1:0]     grant,
   output logic                 out_valid,
   output logic [2:0]           out_rem,
   output logic [ID_W-1:0]      out_id,
   output logic [7:0]           out_len,
   input  logic                 out_ready
);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_HOLD} state_t;

   state_t            state_q,     state_d;
   logic [N_REQ-1:0]  grant_q,     grant_d;
   logic [ID_W-1:0]   owner_q,     owner_d;
   logic [ID_W-1:0]   rr_q,        rr_d;
   logic [2:0]        rem_q,       rem_d;
   logic [7:0]        cnt_q,       cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [2:0]        out_rem_q,   out_rem_d;
   logic [ID_W-1:0]   out_id_q,    out_id_d;
   logic [7:0]        out_len_q,   out_len_d;
`ifdef CRC_FRAME_CHECK_EN
   logic              out_err_q,   out_err_d;
`endif

   logic              pick_found;
   logic [ID_W-1:0]   pick_idx;
   logic              beat;
   logic [2:0]        rem_upd;
   logic [7:0]        cnt_upd;
   logic [3:0]        own_data;

   // Four bit-serial divider steps, MSB of the nibble first.
   function automatic logic [2:0] crc_nibble(input logic [2:0] r_in, input logic [3:0] d);
      logic [2:0] r;
      logic       fb;
      r = r_in;
      for (int k = 3; k >= 0; k--) begin
         fb = r[2] ^ d[k];
         r  = {r[1:0], 1'b0} ^ {2'b00, fb};
      end
      return r;
   endfunction

   // Frame length counter that sticks at its maximum.
   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   // Round-robin pick: first valid requester at or above the rr pointer, wrapping.
   always_comb begin
      int j;
      pick_found = 1'b0;
      pick_idx   = '0;
      j          = 0;
      for (int i = 0; i < N_REQ; i++) begin
         j = int'(rr_q) + i;
         if (j >= N_REQ) j = j - N_REQ;
         if (!pick_found && in_valid[j]) begin
            pick_found = 1'b1;
            pick_idx   = ID_W'(j);
         end
      end
   end

   // Owner datapath: the beat qualifier and the divider/counter values after this beat.
   always_comb begin
      own_data = in_data[int'(owner_q)*4 +: 4];
      beat     = (state_q == ST_BUSY) && in_valid[owner_q] && grant_q[owner_q];
      rem_upd  = crc_nibble(rem_q, own_data);
      cnt_upd  = sat_inc(cnt_q);
   end

   // Next-state logic for the scheduler FSM and its registered outputs.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      owner_d     = owner_q;
      rr_d        = rr_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_rem_d   = out_rem_q;
      out_id_d    = out_id_q;
      out_len_d   = out_len_q;
`ifdef CRC_FRAME_CHECK_EN
      out_err_d   = out_err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               owner_d           = pick_idx;
               rem_d             = '0;
               cnt_d             = '0;
               state_d           = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (beat) begin
               rem_d = rem_upd;
               cnt_d = cnt_upd;
               if (in_last[owner_q]) begin
                  out_rem_d   = rem_upd;
                  out_len_d   = cnt_upd;
                  out_id_d    = owner_q;
                  out_valid_d = 1'b1;
`ifdef CRC_FRAME_CHECK_EN
                  out_err_d   = (rem_upd != in_exp[int'(owner_q)*3 +: 3]);
`endif
                  grant_d     = '0;
                  state_d     = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               rr_d        = (out_id_q == ID_W'(N_REQ - 1)) ? '0 : out_id_q + 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            grant_d     = '0;
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State register; reset discards any partial frame or pending result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         owner_q     <= '0;
         rr_q        <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_rem_q   <= '0;
         out_id_q    <= '0;
         out_len_q   <= '0;
`ifdef CRC_FRAME_CHECK_EN
         out_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         owner_q     <= owner_d;
         rr_q        <= rr_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_rem_q   <= out_rem_d;
         out_id_q    <= out_id_d;
         out_len_q   <= out_len_d;
`ifdef CRC_FRAME_CHECK_EN
         out_err_q   <= out_err_d;
`endif
      end
   end

   // in_ready mirrors the registered grant, so it never depends on in_valid.
   assign grant     = grant_q;
   assign in_ready  = grant_q;
   assign out_valid = out_valid_q;
   assign out_rem   = out_rem_q;
   assign out_id    = out_id_q;
   assign out_len   = out_len_q;
`ifdef CRC_FRAME_CHECK_EN
   assign out_err   = out_err_q;
`endif

endmodule
